// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory,
// with a bounded ownership lock and registered read responses.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_out,
  output logic              dbg_lock_active,
  output logic [7:0]        dbg_lock_cnt
);

  // Handshake: an access completes in the cycle where rN_req && rN_gnt; the
  // requester holds we/addr/wdata stable until then, and a granted read is
  // answered by rN_rvalid for exactly one cycle after the grant.

  typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  lock_state_e       state_q, state_d;
  logic              lock_id_q, lock_id_d;
  logic [7:0]        lock_cnt_q, lock_cnt_d;
  logic              last_owner_q, last_owner_d;
  logic              r0_rvalid_q, r1_rvalid_q;
  logic [DATA_W-1:0] r0_rdata_q, r1_rdata_q;

  logic       any_gnt;
  logic       win_id;
  logic       win_lock;
  logic       owner_req;
  logic [7:0] cnt_inc;

  // Arbitration and memory drive; grants are forced low while reset is held.
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (reset) begin
      if (state_q == LOCKED) begin
        r0_gnt = !lock_id_q && r0_req;
        r1_gnt = lock_id_q && r1_req;
      end else if (r0_req && r1_req) begin
        r0_gnt = last_owner_q;
        r1_gnt = !last_owner_q;
      end else begin
        r0_gnt = r0_req;
        r1_gnt = r1_req;
      end
    end
    any_gnt   = r0_gnt || r1_gnt;
    win_id    = r1_gnt;
    win_lock  = r1_gnt ? r1_lock : r0_lock;
    mem_A     = r1_gnt ? r1_addr : r0_addr;
    mem_WD    = r1_gnt ? r1_wdata : r0_wdata;
    mem_write = (r0_gnt && r0_we) || (r1_gnt && r1_we);
  end

  // Lock sequencing: a lock is dropped on an idle owner cycle, an unlocked
  // grant, or once the owner has held LOCK_MAX consecutive grants.
  always_comb begin
    state_d      = state_q;
    lock_id_d    = lock_id_q;
    lock_cnt_d   = lock_cnt_q;
    last_owner_d = last_owner_q;
    owner_req    = lock_id_q ? r1_req : r0_req;
    cnt_inc      = lock_cnt_q + 8'd1;
    if (any_gnt) begin
      last_owner_d = win_id;
    end
    case (state_q)
      UNLOCKED: begin
        if (any_gnt && win_lock && (LOCK_MAX_C > 8'd1)) begin
          state_d    = LOCKED;
          lock_id_d  = win_id;
          lock_cnt_d = 8'd1;
        end
      end
      LOCKED: begin
        if (!owner_req || !win_lock || (cnt_inc >= LOCK_MAX_C)) begin
          state_d    = UNLOCKED;
          lock_cnt_d = 8'd0;
        end else begin
          lock_cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d    = UNLOCKED;
        lock_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= UNLOCKED;
      lock_id_q    <= 1'b0;
      lock_cnt_q   <= 8'd0;
      last_owner_q <= 1'b1;
      r0_rvalid_q  <= 1'b0;
      r1_rvalid_q  <= 1'b0;
      r0_rdata_q   <= '0;
      r1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      lock_id_q    <= lock_id_d;
      lock_cnt_q   <= lock_cnt_d;
      last_owner_q <= last_owner_d;
      r0_rvalid_q  <= r0_gnt && !r0_we;
      r1_rvalid_q  <= r1_gnt && !r1_we;
      if (r0_gnt && !r0_we) r0_rdata_q <= mem_out;
      if (r1_gnt && !r1_we) r1_rdata_q <= mem_out;
    end
  end

  assign r0_rvalid       = r0_rvalid_q;
  assign r1_rvalid       = r1_rvalid_q;
  assign r0_rdata        = r0_rdata_q;
  assign r1_rdata        = r1_rdata_q;
  assign dbg_lock_active = (state_q == LOCKED);
  assign dbg_lock_cnt    = lock_cnt_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port 256x8 data memory (address, write data, write enable, read data).
- Requester 0 is the core load/store port; requester 1 is the debug/DMA fill port.
- Grants one access per cycle using round-robin priority, with an optional bounded lock for back-to-back bursts.
- Returns registered read data with a one-cycle response valid.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- LOCK_MAX, 15, maximum consecutive granted cycles under lock before the lock is forcibly released; legal range 1..255

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- r0_req  in  1  requester 0 access request
- r0_we  in  1  requester 0 write (1) / read (0)
- r0_lock  in  1  requester 0 requests to keep ownership after this access
- r0_addr  in  ADDR_W  requester 0 address
- r0_wdata  in  DATA_W  requester 0 write data
- r0_gnt  out  1  requester 0 access accepted this cycle (combinational)
- r0_rvalid  out  1  requester 0 read data valid (registered)
- r0_rdata  out  DATA_W  requester 0 read data (registered)
- r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same as requester 0, for requester 1
- mem_A  out  ADDR_W  memory address
- mem_WD  out  DATA_W  memory write data
- mem_write  out  1  memory write enable
- mem_out  in  DATA_W  memory read data; combinational from mem_A

Behaviour:
- Reset (reset low, asynchronous) clears all state:
  - rN_rvalid=0, rN_rdata=0.
  - last_owner=1, so requester 0 wins the first contention.
  - lock_active=0, lock_cnt=0.
  - rN_gnt=0 and mem_write=0 are forced while reset is low.
- Access completes in the cycle where rN_req && rN_gnt. A requester holds req/we/addr/wdata stable until granted. Deasserting req before grant is legal; nothing is performed.
- Arbitration is combinational each cycle:
  - lock_active=1: only lock_id may be granted. The other requester sees gnt=0 even when the owner is idle.
  - Otherwise, one req → that requester is granted.
  - Otherwise, both req → the requester != last_owner is granted.
- Memory drive:
  - mem_A/mem_WD come from the winner.
  - mem_write = winner we.
  - With no grant, mem_write=0 and mem_A/mem_WD hold the requester 0 values (don't-care).
  - The memory commits the write on the same posedge.
- Read path:
  - A granted read samples mem_out into rN_rdata at the posedge ending the grant cycle.
  - rN_rvalid=1 for exactly one following cycle.
  - A granted write produces no rvalid.
  - rN_rdata holds its value until the next read by that requester.
- last_owner updates to the granted id on every grant.
- Lock state machine, two states, UNLOCKED and LOCKED(id):
  - UNLOCKED→LOCKED: on a grant with rN_lock=1; lock_id=N, lock_cnt=1.
  - LOCKED, owner granted with lock=1: lock_cnt++.
  - LOCKED, owner granted with lock=1 and lock_cnt==LOCK_MAX: → UNLOCKED, last_owner=owner, so the other requester wins the next contention.
  - LOCKED, owner granted with lock=0: → UNLOCKED.
  - LOCKED, owner req=0 for a cycle: → UNLOCKED at that posedge. A lock cannot idle-block the other requester for more than one cycle.
- Read-after-write to the same address by consecutive grants returns the newly written data (the memory is written at the earlier posedge).
- Reset asserted mid-access: the pending rvalid is cancelled and the lock is dropped. A write in the reset cycle is suppressed.

Test Plan:
- Reset release, r0 writes 0xA5 to 0x10, then reads 0x10 → r0_gnt both cycles, mem_write=1 only on the first, r0_rvalid=1 two cycles after the write grant with r0_rdata=0xA5.
- Both req every cycle, no lock → grants alternate r0,r1,r0,r1… starting with r0; no cycle grants both.
- r1 lock=1 for 20 consecutive writes with r0 req held, LOCK_MAX=15:
  - r1 granted 15 consecutive cycles, then r0 granted next cycle.
  - r0 never granted while locked.
- r0 locks, then drops req for one cycle while r1 requests → r1 gnt=0 in the idle cycle, r1 granted the next cycle, lock_active=0.
- Simultaneous r0 read 0x20 and r1 write 0x20=0x3C, r1 last owner:
  - r0 granted first and reads the old value.
  - r1 write next; a subsequent r0 read returns 0x3C.
- Assert reset the cycle after an r1 read grant → r1_rvalid stays 0, all gnt=0 during reset, first grant after release goes to r0.
